psram_responder: RTL

Synthesizable octal-PSRAM device emulator: the target end of the 8-bit PSRAM bus driven by the `psram` controller. It oversamples `csn`/`sclk`/`dq` on `clk_100mhz`, decodes command, address and latency phases, and serves byte writes and reads from an internal byte RAM. It is instantiated on the board-less build and in benches in place of the physical chip, wired directly to the controller's `o_psram_csn`, `o_psram_sclk` and data pins.

---
 rtl/psram_responder.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/psram_responder.sv
// psram_responder: octal-PSRAM target emulator.
// Oversamples csn/sclk/dq on clk_100mhz, decodes command / address / latency
// phases and serves byte writes and reads from an internal 2^AW byte RAM.
// Optional feature macro: PSRAM_RESP_READID_EN (command 0x9F returns the ID
// bytes 0x0D, 0x5D, then 0x00 repeating after the normal latency phase).
// Address capture reuses the pointer as a shift register, so AW <= 24.
module psram_responder #(
    parameter int AW      = 12,
    parameter int LATENCY = 4
) (
    input  logic       clk_100mhz,
    input  logic       rstn_i,
    input  logic       i_csn,
    input  logic       i_sclk,
    input  logic [7:0] i_dq,
    output logic [7:0] o_dq,
    output logic       o_dq_oe,
    output logic       o_active,
    output logic [2:0] o_state,
    output logic       o_err
);

    localparam int              DEPTH     = 1 << AW;
    localparam logic [7:0]      CMD_WRITE = 8'h02;
    localparam logic [7:0]      CMD_READ  = 8'h0B;
    localparam logic [7:0]      LAT_LAST  = 8'(LATENCY - 1);
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
`ifdef PSRAM_RESP_READID_EN
    localparam logic [7:0]      CMD_READID = 8'h9F;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_LAT    = 3'd3,
        ST_WDATA  = 3'd4,
        ST_RDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    // ID byte sequence served by the read-ID command
    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h0D;
            2'd1:    b = 8'h5D;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic          csn_meta_r, csn_sync_r, csn_dly_r;
    logic          sclk_meta_r, sclk_sync_r, sclk_dly_r;
    logic [7:0]    dq_meta_r, dq_sync_r;
    logic          csn_fall_s, csn_rise_s, sclk_rise_s, sclk_fall_s;
    logic          cmd_id_s, cmd_known_s, err_set_s, wr_en_s;
    state_t        state_r, state_nxt;
    logic          is_read_r, is_id_r, err_r, active_r, dq_oe_r;
    logic [1:0]    addr_cnt_r, id_idx_r;
    logic [7:0]    lat_cnt_r, dq_out_r, pre_r;
    logic [AW-1:0] ptr_r;
    logic [7:0]    mem_r [0:DEPTH-1];

    // Edge detection: synchronized value vs. its one-cycle delay; a csn rise
    // in the same cycle discards any sclk edge.
    assign csn_fall_s  = csn_dly_r & ~csn_sync_r;
    assign csn_rise_s  = ~csn_dly_r & csn_sync_r;
    assign sclk_rise_s = sclk_sync_r & ~sclk_dly_r & ~csn_rise_s;
    assign sclk_fall_s = ~sclk_sync_r & sclk_dly_r & ~csn_rise_s;

`ifdef PSRAM_RESP_READID_EN
    assign cmd_id_s = (dq_sync_r == CMD_READID);
`else
    assign cmd_id_s = 1'b0;
`endif
    assign cmd_known_s = (dq_sync_r == CMD_WRITE) | (dq_sync_r == CMD_READ) | cmd_id_s;
    assign wr_en_s     = (state_r == ST_WDATA) & sclk_rise_s;

    assign o_dq     = dq_out_r;
    assign o_dq_oe  = dq_oe_r;
    assign o_active = active_r;
    assign o_state  = state_r;
    assign o_err    = err_r;

    // Two-flop synchronizers plus edge-detect delay register for all bus inputs
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            csn_meta_r  <= 1'b1;
            csn_sync_r  <= 1'b1;
            csn_dly_r   <= 1'b1;
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_dly_r  <= 1'b0;
            dq_meta_r   <= 8'h00;
            dq_sync_r   <= 8'h00;
        end else begin
            csn_meta_r  <= i_csn;
            csn_sync_r  <= csn_meta_r;
            csn_dly_r   <= csn_sync_r;
            sclk_meta_r <= i_sclk;
            sclk_sync_r <= sclk_meta_r;
            sclk_dly_r  <= sclk_sync_r;
            dq_meta_r   <= i_dq;
            dq_sync_r   <= dq_meta_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state decode and protocol-error detection
    always_comb begin
        state_nxt = state_r;
        err_set_s = 1'b0;
        if (csn_rise_s) begin
            state_nxt = ST_IDLE;
            if ((state_r == ST_CMD) || (state_r == ST_ADDR) || (state_r == ST_LAT)) begin
                err_set_s = 1'b1;
            end else begin
                err_set_s = 1'b0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (csn_fall_s) state_nxt = ST_CMD;
                    else            state_nxt = ST_IDLE;
                end
                ST_CMD: begin
                    if (sclk_rise_s) begin
                        if (cmd_known_s) begin
                            state_nxt = ST_ADDR;
                        end else begin
                            state_nxt = ST_IGNORE;
                            err_set_s = 1'b1;
                        end
                    end else begin
                        state_nxt = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise_s && (addr_cnt_r == 2'd2)) begin
                        if (!is_read_r)        state_nxt = ST_WDATA;
                        else if (LATENCY == 0) state_nxt = ST_RDATA;
                        else                   state_nxt = ST_LAT;
                    end else begin
                        state_nxt = ST_ADDR;
                    end
                end
                ST_LAT: begin
                    if (sclk_rise_s && (lat_cnt_r == LAT_LAST)) state_nxt = ST_RDATA;
                    else                                        state_nxt = ST_LAT;
                end
                ST_WDATA:  state_nxt = ST_WDATA;
                ST_RDATA:  state_nxt = ST_RDATA;
                ST_IGNORE: state_nxt = ST_IGNORE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Transaction datapath: command/address capture, latency count, pointer, read output
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            is_read_r  <= 1'b0;
            is_id_r    <= 1'b0;
            addr_cnt_r <= 2'd0;
            lat_cnt_r  <= 8'd0;
            id_idx_r   <= 2'd0;
            ptr_r      <= '0;
            dq_out_r   <= 8'h00;
            dq_oe_r    <= 1'b0;
            err_r      <= 1'b0;
            active_r   <= 1'b0;
        end else begin
            err_r    <= err_r | err_set_s;
            active_r <= ~csn_dly_r;
            if (csn_rise_s) dq_oe_r <= 1'b0;
            else            dq_oe_r <= dq_oe_r;
            case (state_r)
                ST_CMD: begin
                    if (sclk_rise_s) begin
                        is_read_r  <= (dq_sync_r != CMD_WRITE);
                        is_id_r    <= cmd_id_s;
                        addr_cnt_r <= 2'd0;
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise_s) begin
                        ptr_r      <= (ptr_r << 4'd8) | AW'(dq_sync_r);
                        addr_cnt_r <= addr_cnt_r + 2'd1;
                        lat_cnt_r  <= 8'd0;
                        id_idx_r   <= 2'd0;
                    end
                end
                ST_LAT: begin
                    if (sclk_rise_s) lat_cnt_r <= lat_cnt_r + 8'd1;
                end
                ST_WDATA: begin
                    if (sclk_rise_s) ptr_r <= ptr_r + PTR_ONE;
                end
                ST_RDATA: begin
                    if (sclk_fall_s) begin
                        dq_oe_r <= 1'b1;
                        if (is_id_r) begin
                            dq_out_r <= id_byte(id_idx_r);
                            if (id_idx_r != 2'd2) id_idx_r <= id_idx_r + 2'd1;
                        end else begin
                            dq_out_r <= pre_r;
                            ptr_r    <= ptr_r + PTR_ONE;
                        end
                    end
                end
                default: begin
                    ptr_r <= ptr_r;
                end
            endcase
        end
    end

    // Byte RAM write port; contents survive reset
    always_ff @(posedge clk_100mhz) begin
        if (wr_en_s) mem_r[ptr_r] <= dq_sync_r;
    end

    // Read prefetch: byte at the pointer is ready long before the next sclk fall
    always_ff @(posedge clk_100mhz) begin
        pre_r <= mem_r[ptr_r];
    end

endmodule
